// File: rtl/edge_threshold_stream_if.sv
// Output stream port of the edge threshold stage.
// Carries one thresholded pixel per transfer plus frame-boundary tags.
//   out_data  : thresholded pixel (PIXEL_BITS)
//   out_valid : source holds a pixel
//   out_ready : sink takes the pixel this cycle
//   out_sop   : pixel is (0,0) of a frame
//   out_eop   : pixel is (W-1,H-1) of a frame
// master = the producing stage, slave = the display/packet writer.
interface edge_threshold_stream_if #(
    parameter int PIXEL_BITS = 8
);
    logic [PIXEL_BITS-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sop;
    logic                  out_eop;

    modport master (
        output out_data,
        output out_valid,
        output out_sop,
        output out_eop,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sop,
        input  out_eop,
        output out_ready
    );
endinterface

// File: rtl/edge_threshold_stream.sv
// Edge threshold stage of the Sobel stream.
// Thresholds each incoming gradient magnitude, tags frame start/end from
// internal x/y counters, buffers results in a first-word-fall-through FIFO
// behind a ready/valid source port and reports the per-frame edge count.
// Ports:
//   clk, reset        : single clock, asynchronous active-high reset
//   pixel_in/_valid   : magnitude stream, no backpressure
//   threshold, mode   : frame parameters, latched at pixel (0,0)
//   out_if (master)   : out_data/out_valid/out_ready/out_sop/out_eop
//   edge_count        : edge pixels in the last completed frame
//   edge_count_valid  : one-cycle pulse when edge_count updates
//   overflow          : sticky, a result was dropped on a full FIFO
module edge_threshold_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIXEL_BITS = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_BITS-1:0] pixel_in,
    input  logic                  pixel_in_valid,
    input  logic [PIXEL_BITS-1:0] threshold,
    input  logic                  mode,
    edge_threshold_stream_if.master out_if,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] edge_count,
    output logic                  edge_count_valid,
    output logic                  overflow
);
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CW = $clog2(IMG_WIDTH*IMG_HEIGHT+1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = PIXEL_BITS + 2;

    localparam logic [XW-1:0]         X_LAST   = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]         Y_LAST   = YW'(IMG_HEIGHT - 1);
    localparam logic [PIXEL_BITS-1:0] ALL_ONES = {PIXEL_BITS{1'b1}};

    // Position and active frame parameters
    logic [XW-1:0]         x_r;
    logic [YW-1:0]         y_r;
    logic [PIXEL_BITS-1:0] thr_active_r;
    logic                  mode_active_r;

    // Stage register S1
    logic [PIXEL_BITS-1:0] s1_data_r;
    logic                  s1_sop_r;
    logic                  s1_eop_r;
    logic                  s1_edge_r;
    logic                  s1_valid_r;

    // FIFO storage; pointers carry one wrap bit to tell full from empty
    logic [EW-1:0]         fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_r;
    logic [AW:0]           rd_ptr_r;

    logic [CW-1:0]         edge_acc_r;
    logic                  overflow_r;
    logic [CW-1:0]         edge_count_r;
    logic                  edge_count_valid_r;

    // Combinational helpers
    logic                  frame_start_s;
    logic                  x_last_s;
    logic                  y_last_s;
    logic [PIXEL_BITS-1:0] thr_use_s;
    logic                  mode_use_s;
    logic                  is_edge_s;
    logic [PIXEL_BITS-1:0] data_s;
    logic                  fifo_empty_s;
    logic                  fifo_full_s;
    logic                  rd_en_s;
    logic                  wr_en_s;
    logic                  drop_s;
    logic [EW-1:0]         head_s;

    // Threshold decision; at frame start the fresh parameters apply to pixel (0,0) itself
    always_comb begin
        frame_start_s = (x_r == '0) && (y_r == '0);
        x_last_s      = (x_r == X_LAST);
        y_last_s      = (y_r == Y_LAST);
        if (frame_start_s) begin
            thr_use_s  = threshold;
            mode_use_s = mode;
        end else begin
            thr_use_s  = thr_active_r;
            mode_use_s = mode_active_r;
        end
        is_edge_s = (pixel_in >= thr_use_s);
        if (!is_edge_s) begin
            data_s = '0;
        end else if (mode_use_s) begin
            data_s = pixel_in;
        end else begin
            data_s = ALL_ONES;
        end
    end

    // Pixel position counters and per-frame parameter latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r           <= '0;
            y_r           <= '0;
            thr_active_r  <= '0;
            mode_active_r <= 1'b0;
        end else if (pixel_in_valid) begin
            if (frame_start_s) begin
                thr_active_r  <= threshold;
                mode_active_r <= mode;
            end
            if (x_last_s) begin
                x_r <= '0;
                y_r <= y_last_s ? '0 : (y_r + YW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end
    end

    // S1 stage register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_sop_r   <= 1'b0;
            s1_eop_r   <= 1'b0;
            s1_edge_r  <= 1'b0;
        end else begin
            s1_valid_r <= pixel_in_valid;
            if (pixel_in_valid) begin
                s1_data_r <= data_s;
                s1_sop_r  <= frame_start_s;
                s1_eop_r  <= x_last_s && y_last_s;
                s1_edge_r <= is_edge_s;
            end
        end
    end

    // FIFO status and handshake; a read frees the slot the same cycle so a full FIFO still accepts
    always_comb begin
        fifo_empty_s = (wr_ptr_r == rd_ptr_r);
        fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        rd_en_s      = !fifo_empty_s && out_if.out_ready;
        wr_en_s      = s1_valid_r && (!fifo_full_s || rd_en_s);
        drop_s       = s1_valid_r && fifo_full_s && !rd_en_s;
        head_s       = fifo_mem_r[rd_ptr_r[AW-1:0]];
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= '0;
            end
        end else begin
            if (wr_en_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= {s1_sop_r, s1_eop_r, s1_data_r};
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end
    end

    // Edge accumulator; counts every edge pixel regardless of FIFO drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_acc_r         <= '0;
            edge_count_r       <= '0;
            edge_count_valid_r <= 1'b0;
        end else begin
            edge_count_valid_r <= 1'b0;
            if (s1_valid_r) begin
                if (s1_eop_r) begin
                    edge_count_r       <= edge_acc_r + {{(CW-1){1'b0}}, s1_edge_r};
                    edge_count_valid_r <= 1'b1;
                    edge_acc_r         <= '0;
                end else begin
                    edge_acc_r <= edge_acc_r + {{(CW-1){1'b0}}, s1_edge_r};
                end
            end
        end
    end

    // Output drive; head fields forced to zero while the FIFO is empty
    always_comb begin
        out_if.out_valid = !fifo_empty_s;
        if (fifo_empty_s) begin
            out_if.out_sop  = 1'b0;
            out_if.out_eop  = 1'b0;
            out_if.out_data = '0;
        end else begin
            out_if.out_sop  = head_s[EW-1];
            out_if.out_eop  = head_s[EW-2];
            out_if.out_data = head_s[PIXEL_BITS-1:0];
        end
    end

    assign edge_count       = edge_count_r;
    assign edge_count_valid = edge_count_valid_r;
    assign overflow         = overflow_r;
endmodule
